// File: rtl/input_sequencer.sv
// ----------------------------------------------------------------------------
// input_sequencer
//
// Replays a stored pattern of 2-bit {x,y} symbols onto the controller M
// input. A small 8-entry pattern buffer is loaded while idle. A start
// request then plays entries 0..len, (reps+1) times over, one symbol per
// clock. While pause is held high the playback is frozen. After the last
// symbol the block produces a one-cycle done pulse and returns to idle.
//
// Ports
//    clock     in   1  rising-edge clock
//    reset     in   1  asynchronous, active-low reset
//    wr_en     in   1  pattern-buffer write strobe (only honoured while idle)
//    wr_addr   in   3  pattern-buffer write address
//    wr_data   in   2  symbol {x,y} to store
//    len       in   3  index of the last pattern entry, sampled with start
//    reps      in   4  extra passes over the pattern, sampled with start
//    start     in   1  begin a sequence (only honoured while idle)
//    pause     in   1  freeze emission while high (only honoured while running)
//    M         out  2  emitted symbol, registered
//    m_valid   out  1  one-cycle strobe per emitted symbol, registered
//    busy      out  1  high while a sequence is running or finishing
//    done      out  1  one-cycle completion pulse, registered
//    sent_cnt  out  8  symbols emitted since the last accepted start
// ----------------------------------------------------------------------------
module input_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [1:0] wr_data,
   input  logic [2:0] len,
   input  logic [3:0] reps,
   input  logic       start,
   input  logic       pause,
   output logic [1:0] M,
   output logic       m_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] sent_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state, state_next;
   logic [2:0] ptr, ptr_next;
   logic [3:0] pass, pass_next;
   logic [2:0] len_lat, len_next;
   logic [1:0] m_next;
   logic       m_valid_next;
   logic       done_next;
   logic [7:0] cnt_next;
   logic       buf_we;
   logic [1:0] buf_mem [8];

   assign busy = (state != IDLE);

   // State and datapath registers. Everything the sequencer remembers
   // between cycles lives here; the next values come from the block below.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         pass     <= 4'd0;
         len_lat  <= 3'd0;
         M        <= 2'b00;
         m_valid  <= 1'b0;
         done     <= 1'b0;
         sent_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         pass     <= pass_next;
         len_lat  <= len_next;
         M        <= m_next;
         m_valid  <= m_valid_next;
         done     <= done_next;
         sent_cnt <= cnt_next;
      end
   end

   // Next-state logic. m_valid and done default low so they can only ever be
   // single-cycle strobes; M and the counters hold unless a state says
   // otherwise. A start in IDLE takes priority over a write in the same
   // cycle, so the write is dropped. The last symbol is the one emitted with
   // the pointer at len_lat on the final pass, and the move to DONE happens
   // on that same edge so no idle gap or extra symbol follows it.
   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      pass_next    = pass;
      len_next     = len_lat;
      m_next       = M;
      m_valid_next = 1'b0;
      done_next    = 1'b0;
      cnt_next     = sent_cnt;
      buf_we       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               ptr_next   = 3'd0;
               pass_next  = reps;
               len_next   = len;
               cnt_next   = 8'd0;
            end else if (wr_en) begin
               buf_we = 1'b1;
            end
         end
         RUN: begin
            if (!pause) begin
               m_next       = buf_mem[ptr];
               m_valid_next = 1'b1;
               cnt_next     = sent_cnt + 8'd1;
               if (ptr == len_lat) begin
                  ptr_next = 3'd0;
                  if (pass == 4'd0) begin
                     state_next = DONE;
                  end else begin
                     pass_next = pass - 4'd1;
                  end
               end else begin
                  ptr_next = ptr + 3'd1;
               end
            end
         end
         DONE: begin
            m_next     = 2'b00;
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pattern buffer. Contents persist across sequences and are cleared only
   // by reset; writes are gated to IDLE by buf_we.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            buf_mem[i] <= 2'b00;
         end
      end else if (buf_we) begin
         buf_mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_input_sequencer.sv
// ----------------------------------------------------------------------------
// tb_input_sequencer
//
// Scoreboard bench for input_sequencer. When a start is issued, the
// reference model expands the stored pattern into the full list of
// (len+1)*(reps+1) symbols and pushes it, together with the expected final
// count, into queues. An independent monitor pops a symbol on every m_valid
// and checks the count on every done pulse.
// ----------------------------------------------------------------------------
module tb_input_sequencer;

   logic       clock;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [1:0] wr_data;
   logic [2:0] len;
   logic [3:0] reps;
   logic       start;
   logic       pause;
   logic [1:0] M;
   logic       m_valid;
   logic       busy;
   logic       done;
   logic [7:0] sent_cnt;

   int         total_checks = 0;
   int         bad_checks   = 0;
   int         last_count   = 0;
   logic [1:0] mdl_buf [8];
   logic [1:0] exp_sym [$];
   int         exp_cnt [$];

   input_sequencer dut (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .len      (len),
      .reps     (reps),
      .start    (start),
      .pause    (pause),
      .M        (M),
      .m_valid  (m_valid),
      .busy     (busy),
      .done     (done),
      .sent_cnt (sent_cnt)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input int act, input int req);
      total_checks++;
      if (act != req) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_buf(input logic [2:0] a, input logic [1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      mdl_buf[a] = d;
   endtask

   // Issue a start and let the model predict the whole symbol stream.
   task automatic launch(input int l, input int r);
      len   = 3'(l);
      reps  = 4'(r);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p <= r; p++) begin
         for (int i = 0; i <= l; i++) begin
            exp_sym.push_back(mdl_buf[i]);
         end
      end
      last_count = (l + 1) * (r + 1);
      exp_cnt.push_back(last_count);
      checkOutput("busy_after_start", int'(busy), 1);
      checkOutput("cnt_cleared", int'(sent_cnt), 0);
   endtask

   // Run until the done pulse, optionally with random pause, bounded.
   task automatic wait_done(input int pause_pct);
      bit seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         pause = ($urandom_range(99) < pause_pct);
         tick();
         if (done) seen = 1'b1;
      end
      pause = 1'b0;
      if (!seen) begin
         checkOutput("done_timeout", 0, 1);
      end else begin
         checkOutput("busy_after_done", int'(busy), 0);
         tick();
         checkOutput("done_one_cycle", int'(done), 0);
         checkOutput("cnt_held", int'(sent_cnt), last_count);
      end
   endtask

   task automatic applyStimulus(input int l, input int r, input int pause_pct);
      launch(l, r);
      wait_done(pause_pct);
   endtask

   // Monitor: compares every emitted symbol and every done pulse against
   // what the model queued.
   always @(negedge clock) begin
      if (reset) begin
         if (m_valid) begin
            if (exp_sym.size() == 0) begin
               checkOutput("extra_symbol", 1, 0);
            end else begin
               checkOutput("symbol", int'(M), int'(exp_sym.pop_front()));
            end
         end
         if (done) begin
            if (exp_cnt.size() == 0) begin
               checkOutput("spurious_done", 1, 0);
            end else begin
               checkOutput("done_cnt", int'(sent_cnt), exp_cnt.pop_front());
               checkOutput("leftover_symbols", exp_sym.size(), 0);
            end
         end
      end
   end

   initial begin
      int n;
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 2'b00;
      len     = 3'd0;
      reps    = 4'd0;
      start   = 1'b0;
      pause   = 1'b0;
      for (int i = 0; i < 8; i++) mdl_buf[i] = 2'b00;

      // Reset state.
      #12;
      checkOutput("reset_M", int'(M), 0);
      checkOutput("reset_m_valid", int'(m_valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_sent_cnt", int'(sent_cnt), 0);
      #10 reset = 1'b1;
      tick();

      // Basic four-symbol playback, with first-symbol latency check.
      write_buf(3'd0, 2'b01);
      write_buf(3'd1, 2'b10);
      write_buf(3'd2, 2'b11);
      write_buf(3'd3, 2'b00);
      launch(3, 0);
      checkOutput("no_valid_at_start", int'(m_valid), 0);
      tick();
      checkOutput("first_sym_latency", int'(m_valid), 1);
      wait_done(0);

      // Repeated short pattern.
      applyStimulus(1, 2, 0);

      // Pause for three cycles after the second symbol.
      launch(3, 0);
      tick();
      tick();
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("paused_m_valid", int'(m_valid), 0);
         checkOutput("paused_M_hold", int'(M), 2);
         checkOutput("paused_cnt", int'(sent_cnt), 2);
      end
      pause = 1'b0;
      wait_done(0);

      // Start and write while busy are ignored.
      launch(3, 1);
      tick();
      tick();
      start   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 2'b11;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      wait_done(0);
      applyStimulus(0, 0, 0);

      // Longest sequence: 128 symbols, counter must not wrap.
      for (int i = 0; i < 8; i++) write_buf(3'(i), 2'($urandom_range(3)));
      applyStimulus(7, 15, 0);

      // Randomized patterns with random pause.
      for (int it = 0; it < 6; it++) begin
         for (int w = 0; w < 3; w++) begin
            write_buf(3'($urandom_range(7)), 2'($urandom_range(3)));
         end
         applyStimulus($urandom_range(7), $urandom_range(4), 30);
      end

      // Reset mid-run after the third symbol.
      launch(7, 0);
      n = 0;
      for (int c = 0; c < 50 && n < 3; c++) begin
         tick();
         if (m_valid) n++;
      end
      if (n < 3) checkOutput("sym_timeout", n, 3);
      reset = 1'b0;
      #1;
      checkOutput("abort_M", int'(M), 0);
      checkOutput("abort_m_valid", int'(m_valid), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_sent_cnt", int'(sent_cnt), 0);
      checkOutput("abort_done", int'(done), 0);
      exp_sym.delete();
      exp_cnt.delete();
      for (int i = 0; i < 8; i++) mdl_buf[i] = 2'b00;
      @(posedge clock);
      @(posedge clock);
      #3 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("idle_after_abort", int'(busy), 0);
      end
      applyStimulus(7, 0, 0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
